wb_arbiter_wdt: RTL

- Round-robin Wishbone arbiter that shares one slave port between NUM_MASTERS masters.
- Adds a per-transfer watchdog: a slave that stalls is cut off, and the owning master receives an error termination.
- Sits between the masters and a single slave (memory model, shared interconnect port), exactly where a plain shared-bus arbiter would sit.
- Exports the current grant and a timeout pulse for monitoring and debug.

---
 rtl/wb_arbiter_wdt_if.sv | 30 +++
 rtl/wb_arbiter_wdt.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_wdt_if.sv
// Wishbone bundle of N ports packed side by side; port i uses slice i of every field.
// The arbiter uses one N-wide instance on its master side and one 1-wide instance toward the slave.
interface wb_arbiter_wdt_if #(
  parameter int N  = 1,
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [N*AW-1:0]     adr;
  logic [N*DW-1:0]     dat_w;
  logic [N*(DW/8)-1:0] sel;
  logic [N-1:0]        we;
  logic [N-1:0]        cyc;
  logic [N-1:0]        stb;
  logic [N*3-1:0]      cti;
  logic [N*2-1:0]      bte;
  logic [N*DW-1:0]     dat_r;
  logic [N-1:0]        ack;
  logic [N-1:0]        err;
  logic [N-1:0]        rty;

  modport master (
    output adr, dat_w, sel, we, cyc, stb, cti, bte,
    input  dat_r, ack, err, rty
  );

  modport slave (
    input  adr, dat_w, sel, we, cyc, stb, cti, bte,
    output dat_r, ack, err, rty
  );
endinterface

// File: rtl/wb_arbiter_wdt.sv
// Round-robin Wishbone arbiter sharing one slave between NUM_MASTERS masters,
// with a per-transfer stall watchdog that aborts the transfer with an error to the owner.
module wb_arbiter_wdt #(
  parameter int NUM_MASTERS = 4,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_ni,
  wb_arbiter_wdt_if.slave        wbm,
  wb_arbiter_wdt_if.master       wbs,
  output logic [NUM_MASTERS-1:0] grant_o,
  output logic                   timeout_o
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam int SW = DW / 8;

  typedef enum logic [1:0] {IDLE, GRANT, ABORT} state_t;

  state_t          state_reg;
  logic [IW-1:0]   last_reg;
  logic [15:0]     wdt_reg;

  logic [AW-1:0]   m_adr [NUM_MASTERS];
  logic [DW-1:0]   m_dat [NUM_MASTERS];
  logic [SW-1:0]   m_sel [NUM_MASTERS];
  logic [2:0]      m_cti [NUM_MASTERS];
  logic [1:0]      m_bte [NUM_MASTERS];

  logic            in_grant;
  logic            own_cyc;
  logic            own_stb;
  logic            term;
  logic            active;
  logic            abort_now;
  logic            route_ack;
  logic            route_err;
  logic            route_rty;
  logic [IW-1:0]   pick_idx;
  logic            pick_vld;
  logic [IW-1:0]   cand;

  generate
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_port
      assign m_adr[gi] = wbm.adr[gi*AW +: AW];
      assign m_dat[gi] = wbm.dat_w[gi*DW +: DW];
      assign m_sel[gi] = wbm.sel[gi*SW +: SW];
      assign m_cti[gi] = wbm.cti[gi*3 +: 3];
      assign m_bte[gi] = wbm.bte[gi*2 +: 2];

      assign wbm.dat_r[gi*DW +: DW] = wbs.dat_r;
      assign wbm.ack[gi] = grant_o[gi] & route_ack;
      assign wbm.err[gi] = grant_o[gi] & route_err;
      assign wbm.rty[gi] = grant_o[gi] & route_rty;
    end
  endgenerate

  assign in_grant  = (state_reg == GRANT);
  assign own_cyc   = wbm.cyc[last_reg];
  assign own_stb   = own_cyc & wbm.stb[last_reg];
  assign term      = wbs.ack[0] | wbs.err[0] | wbs.rty[0];
  assign active    = in_grant & own_stb;
  // A termination in the same cycle the limit is reached takes precedence over the abort.
  assign abort_now = active & ~term & (wdt_reg >= 16'(TIMEOUT));
  assign timeout_o = abort_now;

  assign route_ack = in_grant & wbs.ack[0];
  assign route_err = in_grant & (wbs.err[0] | abort_now);
  assign route_rty = in_grant & wbs.rty[0];

  // Lowest offset from last_reg+1 wins; scanning downward lets the nearest requester overwrite.
  always_comb begin
    pick_idx = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      cand = IW'((int'(last_reg) + k) % NUM_MASTERS);
      if (wbm.cyc[cand]) begin
        pick_idx = cand;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    wbs.adr   = '0;
    wbs.dat_w = '0;
    wbs.sel   = '0;
    wbs.we    = '0;
    wbs.cti   = '0;
    wbs.bte   = '0;
    wbs.cyc   = '0;
    wbs.stb   = '0;
    if (in_grant) begin
      wbs.adr   = m_adr[last_reg];
      wbs.dat_w = m_dat[last_reg];
      wbs.sel   = m_sel[last_reg];
      wbs.we    = wbm.we[last_reg];
      wbs.cti   = m_cti[last_reg];
      wbs.bte   = m_bte[last_reg];
      wbs.cyc   = own_cyc & ~abort_now;
      wbs.stb   = own_stb & ~abort_now;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_reg <= IDLE;
      grant_o   <= '0;
      last_reg  <= IW'(NUM_MASTERS - 1);
      wdt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          wdt_reg <= '0;
          if (pick_vld) begin
            grant_o   <= NUM_MASTERS'(1) << pick_idx;
            last_reg  <= pick_idx;
            state_reg <= GRANT;
          end
        end
        GRANT: begin
          if (active && !term && !abort_now)
            wdt_reg <= (wdt_reg == 16'hFFFF) ? wdt_reg : wdt_reg + 16'd1;
          else
            wdt_reg <= '0;
          if (!own_cyc) begin
            grant_o   <= '0;
            state_reg <= IDLE;
          end else if (abort_now) begin
            state_reg <= ABORT;
          end
        end
        ABORT: begin
          wdt_reg <= '0;
          if (!own_cyc) begin
            grant_o   <= '0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
